// File: rtl/frv_dmem_arbiter_pkg.sv
// Shared constants and sizing helpers for the two-port data-memory arbiter.
package frv_dmem_arbiter_pkg;

  localparam logic FRV_DMEM_PORT_LSU = 1'b0;
  localparam logic FRV_DMEM_PORT_AUX = 1'b1;

  function automatic int unsigned frv_dmem_ptr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  function automatic int unsigned frv_dmem_cnt_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/frv_dmem_id_fifo.sv
// In-order FIFO of 1-bit owner IDs for granted-but-unresponded transactions.
module frv_dmem_id_fifo
  import frv_dmem_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = frv_dmem_ptr_w(DEPTH),
  localparam int unsigned CW    = frv_dmem_cnt_w(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          i_push,
  input  logic          i_push_id,
  input  logic          i_pop,
  output logic          o_head_c,
  output logic          o_full_c,
  output logic          o_empty_c,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_id;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_head_c  = r_mem[r_rptr];
  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/frv_dmem_arbiter.sv
// Round-robin arbiter sharing the core dmem port between the LSU (port 0)
// and an auxiliary requester (port 1), with in-order response routing.
module frv_dmem_arbiter
  import frv_dmem_arbiter_pkg::*;
#(
  parameter int unsigned XL              = 31,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,

  input  logic        s0_req,
  input  logic        s0_wen,
  input  logic [3:0]  s0_strb,
  input  logic [XL:0] s0_wdata,
  input  logic [XL:0] s0_addr,
  output logic        s0_gnt,
  output logic        s0_recv,
  input  logic        s0_ack,
  output logic [XL:0] s0_rdata,
  output logic        s0_error,

  input  logic        s1_req,
  input  logic        s1_wen,
  input  logic [3:0]  s1_strb,
  input  logic [XL:0] s1_wdata,
  input  logic [XL:0] s1_addr,
  output logic        s1_gnt,
  output logic        s1_recv,
  input  logic        s1_ack,
  output logic [XL:0] s1_rdata,
  output logic        s1_error,

  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [XL:0] m_wdata,
  output logic [XL:0] m_addr,
  input  logic        m_gnt,
  input  logic        m_recv,
  output logic        m_ack,
  input  logic [XL:0] m_rdata,
  input  logic        m_error,

  output logic        spurious_rsp
);

  localparam int unsigned CW = frv_dmem_cnt_w(MAX_OUTSTANDING);

  logic          r_lock;
  logic          r_lock_id;
  logic          r_last_grant;

  logic          w_sel;
  logic          w_sel_req;
  logic          w_fire;
  logic          w_pop;
  logic          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // A stalled or full-blocked requester keeps ownership until its handshake.
  always_comb begin
    w_sel = FRV_DMEM_PORT_LSU;
    if (r_lock) begin
      w_sel = r_lock_id;
    end else if (s0_req && s1_req) begin
      w_sel = ~r_last_grant;
    end else if (s1_req) begin
      w_sel = FRV_DMEM_PORT_AUX;
    end
  end

  assign w_sel_req = (w_sel == FRV_DMEM_PORT_AUX) ? s1_req : s0_req;
  assign w_fire    = m_req && m_gnt;
  assign s0_gnt    = w_fire && (w_sel == FRV_DMEM_PORT_LSU);
  assign s1_gnt    = w_fire && (w_sel == FRV_DMEM_PORT_AUX);

  always_comb begin
    m_req   = w_sel_req && !w_full;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    m_addr  = '0;
    if (m_req) begin
      if (w_sel == FRV_DMEM_PORT_AUX) begin
        m_wen   = s1_wen;
        m_strb  = s1_strb;
        m_wdata = s1_wdata;
        m_addr  = s1_addr;
      end else begin
        m_wen   = s0_wen;
        m_strb  = s0_strb;
        m_wdata = s0_wdata;
        m_addr  = s0_addr;
      end
    end
  end

  // Responses with nothing outstanding are drained and flagged.
  always_comb begin
    s0_recv      = 1'b0;
    s1_recv      = 1'b0;
    s0_rdata     = '0;
    s1_rdata     = '0;
    s0_error     = 1'b0;
    s1_error     = 1'b0;
    m_ack        = 1'b0;
    spurious_rsp = 1'b0;
    w_pop        = 1'b0;
    if (w_empty) begin
      m_ack        = m_recv;
      spurious_rsp = m_recv;
    end else begin
      m_ack = (w_head == FRV_DMEM_PORT_AUX) ? s1_ack : s0_ack;
      w_pop = m_recv && m_ack;
      if (m_recv) begin
        if (w_head == FRV_DMEM_PORT_AUX) begin
          s1_recv  = 1'b1;
          s1_rdata = m_rdata;
          s1_error = m_error;
        end else begin
          s0_recv  = 1'b1;
          s0_rdata = m_rdata;
          s0_error = m_error;
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_lock       <= 1'b0;
      r_lock_id    <= FRV_DMEM_PORT_LSU;
      r_last_grant <= FRV_DMEM_PORT_AUX;
    end else begin
      r_lock    <= w_sel_req && !w_fire;
      r_lock_id <= w_sel;
      if (w_fire) begin
        r_last_grant <= w_sel;
      end
    end
  end

  frv_dmem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .i_push    (w_fire),
    .i_push_id (w_sel),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  a_fifo_flags: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (w_full == (w_count == CW'(MAX_OUTSTANDING))) && (w_empty == (w_count == '0)));

endmodule
